// File: rtl/dmem_wait_ctrl.sv
// rtl/dmem_wait_ctrl.sv - multi-cycle data memory with programmable wait-state stall controller
// Optional feature macro: DMEM_BOUNDS_CHECK_EN (adds Mem_Err, blocks out-of-range accesses)
module dmem_wait_ctrl #(
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Mem_Read,
    input  logic        Mem_Write,
    input  logic [15:0] Addr,
    input  logic [15:0] Write_Data,
    output logic [15:0] Mem_Out,
    output logic        Mem_Valid,
`ifdef DMEM_BOUNDS_CHECK_EN
    output logic        Mem_Err,
`endif
    output logic        Mem_Stall
);

    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic [3:0]             cnt;
    logic [ADDR_BITS-1:0]   lat_addr;
    logic [15:0]            lat_data;
    logic                   lat_store;
    logic                   req;
    logic                   enter_done;
    logic [ADDR_BITS-1:0]   acc_addr;
    logic [15:0]            acc_data;
    logic                   acc_store;
    logic                   acc_err;
    logic [15:0]            mem [0:DEPTH-1];

`ifdef DMEM_BOUNDS_CHECK_EN
    logic                   lat_err;
    logic                   addr_hi_set;
    assign addr_hi_set = ((Addr >> ADDR_BITS) != 16'd0);
`else
    logic                   unused_addr_hi;
    assign unused_addr_hi = |(Addr >> ADDR_BITS);
`endif

    assign req = Mem_Read | Mem_Write;

    // Access operands: live inputs while still in IDLE (zero-wait path), latched copies afterwards
    always_comb begin
        acc_addr  = lat_addr;
        acc_data  = lat_data;
        acc_store = lat_store;
        acc_err   = 1'b0;
`ifdef DMEM_BOUNDS_CHECK_EN
        acc_err   = lat_err;
`endif
        if (state == IDLE) begin
            acc_addr  = Addr[ADDR_BITS-1:0];
            acc_data  = Write_Data;
            acc_store = Mem_Write;
`ifdef DMEM_BOUNDS_CHECK_EN
            acc_err   = addr_hi_set;
`endif
        end
    end

    // Next-state decode and combinational stall
    always_comb begin
        next_state = state;
        Mem_Stall  = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    Mem_Stall  = 1'b1;
                    next_state = (WAIT_CYCLES == 0) ? DONE : WAIT;
                end
            end
            WAIT: begin
                Mem_Stall = 1'b1;
                if (cnt == 4'd0) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign enter_done = (next_state == DONE);

    // State register, wait counter, request latches and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            lat_addr  <= '0;
            lat_data  <= 16'h0000;
            lat_store <= 1'b0;
            Mem_Out   <= 16'h0000;
            Mem_Valid <= 1'b0;
`ifdef DMEM_BOUNDS_CHECK_EN
            lat_err   <= 1'b0;
            Mem_Err   <= 1'b0;
`endif
        end else begin
            state     <= next_state;
            Mem_Valid <= enter_done;
`ifdef DMEM_BOUNDS_CHECK_EN
            Mem_Err   <= enter_done & acc_err;
`endif
            if (state == IDLE && req) begin
                lat_addr  <= Addr[ADDR_BITS-1:0];
                lat_data  <= Write_Data;
                lat_store <= Mem_Write;
                cnt       <= CNT_INIT;
`ifdef DMEM_BOUNDS_CHECK_EN
                lat_err   <= addr_hi_set;
`endif
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (enter_done) begin
                if (acc_err) begin
                    Mem_Out <= 16'hDEAD;
                end else if (acc_store) begin
                    Mem_Out <= acc_data;
                end else begin
                    Mem_Out <= mem[acc_addr];
                end
            end
        end
    end

    // Array write on the edge entering DONE; never while reset is asserted
    always_ff @(posedge clk) begin
        if (rst_n && enter_done && acc_store && !acc_err) begin
            mem[acc_addr] <= acc_data;
        end
    end

endmodule
